// File: rtl/arty_rst_seq.sv
// Board reset sequencer: pulses the MMCM reset until lock is seen and holds,
// then releases the peripheral, system and core reset domains in stages.
module arty_rst_seq #(
    parameter int MMCM_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 200,
    parameter int LOCK_STABLE     = 32,
    parameter int STAGE_GAP       = 8
) (
    input  logic       clk_in,
    input  logic       resetn,
    input  logic       mmcm_locked,
    input  logic       wdt_rst_req,
    input  logic       sw_rst_req,
    output logic       mmcm_resetn,
    output logic       periph_resetn,
    output logic       sys_resetn,
    output logic       core_resetn,
    output logic [1:0] rst_cause,
    output logic       seq_busy
);

    localparam int MAX_AB = (MMCM_RST_CYCLES > LOCK_TIMEOUT) ? MMCM_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD = (LOCK_STABLE > STAGE_GAP) ? LOCK_STABLE : STAGE_GAP;
    localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAXP + 1);

    localparam logic [CW-1:0] C_MR   = CW'(MMCM_RST_CYCLES - 1);
    localparam logic [CW-1:0] C_TO   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] C_LS   = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] C_GAP  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] C_MAX  = '1;

    typedef enum logic [2:0] {
        S_MMCM_RST,
        S_WAIT_LOCK,
        S_LOCK_STABLE,
        S_REL_PERIPH,
        S_REL_SYS,
        S_REL_CORE,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      sync_q;
    logic [1:0]      cause_q, cause_d;
    logic            mmcm_q, per_q, sys_q, core_q, busy_q;
    logic            lock_s;

    assign lock_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            S_MMCM_RST:    if (cnt_q == C_MR) state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (lock_s)             state_d = S_LOCK_STABLE;
                else if (cnt_q == C_TO) state_d = S_MMCM_RST;
            end
            S_LOCK_STABLE: begin
                if (!lock_s)            state_d = S_WAIT_LOCK;
                else if (cnt_q == C_LS) state_d = S_REL_PERIPH;
            end
            default: begin
                // Lock loss outranks watchdog, which outranks software.
                if (!lock_s) begin
                    state_d = S_MMCM_RST;
                    cause_d = 2'd1;
                end else if (wdt_rst_req) begin
                    state_d = S_LOCK_STABLE;
                    cause_d = 2'd2;
                end else if (sw_rst_req) begin
                    state_d = S_LOCK_STABLE;
                    cause_d = 2'd3;
                end else begin
                    case (state_q)
                        S_REL_PERIPH: if (cnt_q == C_GAP) state_d = S_REL_SYS;
                        S_REL_SYS:    if (cnt_q == C_GAP) state_d = S_REL_CORE;
                        S_REL_CORE:   state_d = S_RUN;
                        default:      state_d = state_q;
                    endcase
                end
            end
        endcase

        if (state_d != state_q) cnt_d = '0;
        else if (cnt_q == C_MAX) cnt_d = cnt_q;
        else                     cnt_d = cnt_q + 1'b1;
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_MMCM_RST;
            cnt_q   <= '0;
            sync_q  <= '0;
            cause_q <= 2'd0;
            mmcm_q  <= 1'b0;
            per_q   <= 1'b0;
            sys_q   <= 1'b0;
            core_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= {sync_q[0], mmcm_locked};
            cause_q <= cause_d;
            mmcm_q  <= (state_d != S_MMCM_RST);
            per_q   <= (state_d inside {S_REL_PERIPH, S_REL_SYS, S_REL_CORE, S_RUN});
            sys_q   <= (state_d inside {S_REL_SYS, S_REL_CORE, S_RUN});
            core_q  <= (state_d inside {S_REL_CORE, S_RUN});
            busy_q  <= (state_d != S_RUN);
        end
    end

    assign mmcm_resetn   = mmcm_q;
    assign periph_resetn = per_q;
    assign sys_resetn    = sys_q;
    assign core_resetn   = core_q;
    assign rst_cause     = cause_q;
    assign seq_busy      = busy_q;

endmodule

// File: tb/tb_arty_rst_seq.sv
// Bench for arty_rst_seq: phase/dwell-time reference model checked every cycle,
// directed scenarios with literal timing checks, then random lock/request traffic.
module tb_arty_rst_seq;

    localparam int MR_N  = 16;
    localparam int TO_N  = 200;
    localparam int LS_N  = 32;
    localparam int GAP_N = 8;

    localparam int P_MR = 0, P_WL = 1, P_LS = 2, P_RP = 3, P_RS = 4, P_RC = 5, P_RUN = 6;

    logic clk_in = 1'b0;
    logic resetn = 1'b0;
    logic mmcm_locked = 1'b0;
    logic wdt_rst_req = 1'b0;
    logic sw_rst_req = 1'b0;
    logic mmcm_resetn, periph_resetn, sys_resetn, core_resetn, seq_busy;
    logic [1:0] rst_cause;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    arty_rst_seq #(
        .MMCM_RST_CYCLES(MR_N), .LOCK_TIMEOUT(TO_N), .LOCK_STABLE(LS_N), .STAGE_GAP(GAP_N)
    ) dut (
        .clk_in(clk_in), .resetn(resetn), .mmcm_locked(mmcm_locked),
        .wdt_rst_req(wdt_rst_req), .sw_rst_req(sw_rst_req),
        .mmcm_resetn(mmcm_resetn), .periph_resetn(periph_resetn),
        .sys_resetn(sys_resetn), .core_resetn(core_resetn),
        .rst_cause(rst_cause), .seq_busy(seq_busy)
    );

    always #5 clk_in = ~clk_in;

    // Reference: which phase we are in and how many cycles of it remain.
    int       m_ph = P_MR;
    int       m_left = MR_N;
    int       m_cause = 0;
    logic     m_l1 = 1'b0, m_l2 = 1'b0;

    always @(posedge clk_in or negedge resetn) begin : model
        int ph, left, cause;
        if (!resetn) begin
            m_l1 <= 1'b0; m_l2 <= 1'b0;
            m_ph <= P_MR; m_left <= MR_N; m_cause <= 0;
        end else begin
            ph = m_ph; left = m_left; cause = m_cause;
            if (ph == P_MR) begin
                if (left == 1) begin ph = P_WL; left = TO_N; end else left--;
            end else if (ph == P_WL) begin
                if (m_l2) begin ph = P_LS; left = LS_N; end
                else if (left == 1) begin ph = P_MR; left = MR_N; end
                else left--;
            end else if (ph == P_LS) begin
                if (!m_l2) begin ph = P_WL; left = TO_N; end
                else if (left == 1) begin ph = P_RP; left = GAP_N; end
                else left--;
            end else begin
                if (!m_l2) begin ph = P_MR; left = MR_N; cause = 1; end
                else if (wdt_rst_req) begin ph = P_LS; left = LS_N; cause = 2; end
                else if (sw_rst_req) begin ph = P_LS; left = LS_N; cause = 3; end
                else if (ph == P_RP || ph == P_RS) begin
                    if (left == 1) begin ph = ph + 1; left = (ph == P_RS) ? GAP_N : 1; end
                    else left--;
                end else if (ph == P_RC) ph = P_RUN;
            end
            m_ph <= ph; m_left <= left; m_cause <= cause;
            m_l1 <= mmcm_locked; m_l2 <= m_l1;
        end
    end

    function automatic logic [6:0] exp_vec();
        return {m_ph != P_MR, m_ph >= P_RP, m_ph >= P_RS, m_ph >= P_RC,
                2'(m_cause), m_ph != P_RUN};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {mmcm_resetn, periph_resetn, sys_resetn, core_resetn, rst_cause, seq_busy};
    endfunction

    task automatic cmp_model();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL model_cmp cyc=%0d got={mm,per,sys,core,cause,busy}=%b expected %b",
                     cyc, dut_vec(), exp_vec());
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        cmp_model();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) tick();
        chk("reset_vec", int'(dut_vec()), 7'b0000001);
        resetn = 1'b1;
        cyc = 0;
    endtask

    initial begin
        // Power-on, lock 50 cycles after release.
        do_reset();
        run_to(15);  chk("po_mmcm_low15", mmcm_resetn, 0);
        run_to(16);  chk("po_mmcm_high16", mmcm_resetn, 1);
        run_to(50);  mmcm_locked = 1'b1;
        run_to(84);  chk("po_per_hold", periph_resetn, 0);
        run_to(85);  chk("po_per_rel", periph_resetn, 1);
        chk("po_sys_hold", sys_resetn, 0);
        run_to(93);  chk("po_sys_rel", sys_resetn, 1);
        chk("po_core_hold", core_resetn, 0);
        run_to(101); chk("po_core_rel", core_resetn, 1);
        chk("po_busy_rc", seq_busy, 1);
        run_to(102); chk("po_busy_run", seq_busy, 0);
        chk("po_cause", rst_cause, 0);

        // Watchdog and software together: watchdog wins, MMCM untouched.
        wdt_rst_req = 1'b1; sw_rst_req = 1'b1;
        tick();
        wdt_rst_req = 1'b0; sw_rst_req = 1'b0;
        chk("wdt_cause", rst_cause, 2);
        chk("wdt_mmcm", mmcm_resetn, 1);
        chk("wdt_per", periph_resetn, 0);
        repeat (60) tick();
        chk("wdt_rerun", seq_busy, 0);

        // Lock loss coincident (at lock_s) with a software request.
        mmcm_locked = 1'b0;
        tick(); tick();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        chk("ll_cause", rst_cause, 1);
        chk("ll_mmcm", mmcm_resetn, 0);
        chk("ll_core", core_resetn, 0);
        mmcm_locked = 1'b1;
        repeat (15) tick();
        chk("ll_mmcm_15", mmcm_resetn, 0);
        tick();
        chk("ll_mmcm_16", mmcm_resetn, 1);
        repeat (100) tick();
        chk("ll_rerun", seq_busy, 0);
        chk("ll_cause_hold", rst_cause, 1);

        // One-cycle lock glitch during stable count, then reset in REL_SYS.
        mmcm_locked = 1'b0;
        do_reset();
        run_to(50);  mmcm_locked = 1'b1;
        run_to(72);  mmcm_locked = 1'b0;
        run_to(73);  mmcm_locked = 1'b1;
        run_to(107); chk("gl_per_hold", periph_resetn, 0);
        run_to(108); chk("gl_per_rel", periph_resetn, 1);
        run_to(118); chk("gl_in_rel_sys", sys_resetn, 1);
        #2 resetn = 1'b0;
        #1 chk("async_rst_vec", int'(dut_vec()), 7'b0000001);
        tick();

        // Lock never arrives: periodic MMCM reset pulses.
        mmcm_locked = 1'b0;
        do_reset();
        run_to(16);  chk("nl_mmcm_16", mmcm_resetn, 1);
        run_to(215); chk("nl_mmcm_215", mmcm_resetn, 1);
        run_to(216); chk("nl_mmcm_216", mmcm_resetn, 0);
        run_to(231); chk("nl_mmcm_231", mmcm_resetn, 0);
        run_to(232); chk("nl_mmcm_232", mmcm_resetn, 1);
        chk("nl_per", periph_resetn, 0);

        // Random lock drops and request pulses.
        mmcm_locked = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (mmcm_locked) begin
                if ($urandom_range(0, 299) == 0) mmcm_locked = 1'b0;
            end else if ($urandom_range(0, 9) == 0) mmcm_locked = 1'b1;
            wdt_rst_req = ($urandom_range(0, 79) == 0);
            sw_rst_req  = ($urandom_range(0, 79) == 0);
            tick();
        end
        wdt_rst_req = 1'b0; sw_rst_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arty_rst_seq.md
ARTY_RST_SEQ -- requirements
Module: arty_rst_seq

Interface
REQ-001 SHALL have parameter MMCM_RST_CYCLES, default 16, cycles mmcm_resetn is held low per MMCM reset pulse.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 200, max cycles to wait for lock before retrying the MMCM reset.
REQ-003 SHALL have parameter LOCK_STABLE, default 32, consecutive synchronized-lock-high cycles required before releasing resets.
REQ-004 SHALL have parameter STAGE_GAP, default 8, cycles between successive reset-domain releases.
REQ-005 SHALL have ports: clk_in  input  1  free-running board clock.
REQ-006 SHALL have: resetn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have: mmcm_locked  input  1  MMCM lock, asynchronous to clk_in.
REQ-008 SHALL have: wdt_rst_req  input  1  watchdog reset request, single-cycle pulse.
REQ-009 SHALL have: sw_rst_req  input  1  software reset request, single-cycle pulse.
REQ-010 SHALL have: mmcm_resetn  output  1  MMCM reset, active-low.
REQ-011 SHALL have: periph_resetn, sys_resetn, core_resetn  output  1 each  staged domain resets, active-low.
REQ-012 SHALL have: rst_cause  output  2  last reset cause: 0 power-on, 1 lock loss, 2 watchdog, 3 software.
REQ-013 SHALL have: seq_busy  output  1  high whenever state is not RUN.

Function
REQ-014 SHALL pass mmcm_locked through a 2-flop synchronizer; all lock decisions use the synchronized value (lock_s).
REQ-015 SHALL implement FSM states MMCM_RST, WAIT_LOCK, LOCK_STABLE, REL_PERIPH, REL_SYS, REL_CORE, RUN, driven by one cycle counter cleared on each state entry.
REQ-016 SHALL drive all outputs from registers; no combinational output paths.
REQ-017 MMCM_RST: mmcm_resetn=0 and all domain resets low for MMCM_RST_CYCLES cycles, then -> WAIT_LOCK with mmcm_resetn=1.
REQ-018 WAIT_LOCK: lock_s=1 -> LOCK_STABLE; counter reaching LOCK_TIMEOUT with lock_s=0 -> MMCM_RST (retry, unlimited).
REQ-019 LOCK_STABLE: lock_s=0 any cycle -> WAIT_LOCK (counter restart); LOCK_STABLE consecutive high cycles -> REL_PERIPH.
REQ-020 REL_PERIPH: periph_resetn=1 on entry; after STAGE_GAP cycles -> REL_SYS.
REQ-021 REL_SYS: sys_resetn=1 on entry; after STAGE_GAP cycles -> REL_CORE.
REQ-022 REL_CORE: core_resetn=1 on entry; next cycle -> RUN.
REQ-023 Release order SHALL be strictly periph, sys, core; assertion SHALL be all three simultaneously.
REQ-024 Any state after WAIT_LOCK: lock_s=0 SHALL -> MMCM_RST, all domain resets low next cycle, rst_cause=1 (in LOCK_STABLE, REQ-019 applies instead).
REQ-025 RUN or REL_*: wdt_rst_req -> all domain resets low next cycle, rst_cause=2, -> LOCK_STABLE (no MMCM reset).
REQ-026 RUN or REL_*: sw_rst_req -> same as REQ-025 with rst_cause=3.
REQ-027 Simultaneous events priority: lock loss > watchdog > software; only the winner's cause is recorded.
REQ-028 wdt_rst_req/sw_rst_req in MMCM_RST, WAIT_LOCK, LOCK_STABLE SHALL be ignored.
REQ-029 Counter width SHALL cover the largest parameter; counter SHALL saturate, never wrap.

Reset
REQ-030 resetn=0 SHALL asynchronously force state MMCM_RST, counter 0, synchronizer 0, mmcm_resetn=0, all domain resets 0, rst_cause=0, seq_busy=1.
REQ-031 resetn mid-sequence SHALL abort immediately; resetn deassertion restarts from REQ-017.
REQ-032 rst_cause SHALL hold its value across lock-loss/watchdog/software sequences; only resetn clears it.

Verification
REQ-033 Power-on, locked rises 50 cycles after resetn release -> mmcm_resetn high at cycle 16; periph/sys/core release 32 stable cycles after lock_s, spaced 8 cycles; rst_cause=0; seq_busy low in RUN.
REQ-034 locked never rises -> mmcm_resetn pulses low 16 cycles every 216 cycles; domain resets stay low.
REQ-035 locked glitches low 1 cycle at stable count 20 -> stable count restarts; release 32 cycles after re-lock.
REQ-036 In RUN, wdt_rst_req and sw_rst_req same cycle -> resets low next cycle, rst_cause=2, mmcm_resetn stays 1, staged re-release.
REQ-037 In RUN, locked drops together with sw_rst_req -> MMCM_RST entered, rst_cause=1, mmcm_resetn low 16 cycles.
REQ-038 resetn asserted during REL_SYS -> all outputs to reset values asynchronously; rst_cause=0.
